// File: rtl/phase_mod_pipe.sv
// Complex rotator: out = bb * ph (or bb * conj(ph)), round-half-up scaled by 2^-(W-1), saturated.
// Latency: 3 register stages (input, products, output); one sample per clock.
// Backpressure: one enable stalls every stage together; in_ready = !out_valid || out_ready.
module phase_mod_pipe #(
    parameter int W     = 12,
    parameter int CNT_W = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_conj,
    input  logic signed [W-1:0] bb_re,
    input  logic signed [W-1:0] bb_im,
    input  logic signed [W-1:0] ph_re,
    input  logic signed [W-1:0] ph_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic [CNT_W-1:0]    sat_count,
    input  logic                sat_clr
);

    localparam int SW = 2*W + 1;

    typedef struct packed {
        logic                conj;
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic signed [W-1:0] c;
        logic signed [W-1:0] d;
    } s1_t;

    typedef struct packed {
        logic                  conj;
        logic signed [2*W-1:0] ac;
        logic signed [2*W-1:0] bd;
        logic signed [2*W-1:0] ad;
        logic signed [2*W-1:0] bc;
    } s2_t;

    localparam logic signed [SW-1:0] HALF  = {{(SW-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
    localparam logic signed [SW-1:0] Y_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] Y_MIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [W-1:0]         O_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         O_MIN = {1'b1, {(W-1){1'b0}}};

    logic en;
    logic s1_vld, s2_vld;
    s1_t  s1_dat;
    s2_t  s2_dat;

    logic signed [SW-1:0] sum_re, sum_im, sh_re, sh_im;
    logic [W-1:0]         clp_re, clp_im;
    logic                 clip;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else if (en) begin
            s1_vld      <= in_valid;
            s1_dat.conj <= in_conj;
            s1_dat.a    <= bb_re;
            s1_dat.b    <= bb_im;
            s1_dat.c    <= ph_re;
            s1_dat.d    <= ph_im;
            s2_vld      <= s1_vld;
            s2_dat.conj <= s1_dat.conj;
            s2_dat.ac   <= $signed(s1_dat.a) * $signed(s1_dat.c);
            s2_dat.bd   <= $signed(s1_dat.b) * $signed(s1_dat.d);
            s2_dat.ad   <= $signed(s1_dat.a) * $signed(s1_dat.d);
            s2_dat.bc   <= $signed(s1_dat.b) * $signed(s1_dat.c);
        end
    end

    // Sums are one bit wider than the products, so they never overflow before scaling.
    always_comb begin
        sum_re = '0;
        sum_im = '0;
        if (s2_dat.conj) begin
            sum_re = SW'($signed(s2_dat.ac)) + SW'($signed(s2_dat.bd));
            sum_im = SW'($signed(s2_dat.bc)) - SW'($signed(s2_dat.ad));
        end else begin
            sum_re = SW'($signed(s2_dat.ac)) - SW'($signed(s2_dat.bd));
            sum_im = SW'($signed(s2_dat.ad)) + SW'($signed(s2_dat.bc));
        end
        sh_re = (sum_re + HALF) >>> (W-1);
        sh_im = (sum_im + HALF) >>> (W-1);
    end

    always_comb begin
        clp_re = sh_re[W-1:0];
        clp_im = sh_im[W-1:0];
        clip   = 1'b0;
        if (sh_re > Y_MAX) begin
            clp_re = O_MAX;
            clip   = 1'b1;
        end else if (sh_re < Y_MIN) begin
            clp_re = O_MIN;
            clip   = 1'b1;
        end
        if (sh_im > Y_MAX) begin
            clp_im = O_MAX;
            clip   = 1'b1;
        end else if (sh_im < Y_MIN) begin
            clp_im = O_MIN;
            clip   = 1'b1;
        end
    end

    // Output data only updates on valid samples so it holds through bubbles.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (en) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_re <= $signed(clp_re);
                out_im <= $signed(clp_im);
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (en && s2_vld && clip && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule
